// File: rtl/reg_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : reg_cmd_master
// Purpose  : Turns single register commands into register-bank accesses and
//            returns one held response per command. A stalled access is
//            aborted with an error response.
// Revision : 1.0 - initial release
// ============================================================================
module reg_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  sel,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_DATA = 2'd2
    } state_t;

    // Counter value in the stall cycle that exhausts the budget.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nxt;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_wr;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_rsp_load;
    logic                  w_rsp_wr;
    logic [DATA_WIDTH-1:0] w_rsp_rdata;
    logic                  w_rsp_err;

    // A command may enter only when the response slot is empty or emptying.
    assign w_cmd_ready = (r_state == S_IDLE) && (!r_rsp_valid || rsp_ready);
    assign w_accept    = cmd_valid && w_cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rsp_load  = 1'b0;
        w_rsp_wr    = r_wr;
        w_rsp_rdata = '0;
        w_rsp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_ISSUE: begin
                if (ready) begin
                    if (r_wr) begin
                        w_rsp_load  = 1'b1;
                        w_rsp_wr    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RD_DATA;
                    end
                end else if (r_cnt == c_TO_LAST) begin
                    w_rsp_load  = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RD_DATA: begin
                w_rsp_load  = 1'b1;
                w_rsp_wr    = 1'b0;
                w_rsp_rdata = rdata;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Bank-side command registers hold their value between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= cmd_wr;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= w_rsp_wr;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign sel       = (r_state == S_ISSUE) || (r_state == S_RD_DATA);
    assign addr      = r_addr;
    assign wr        = r_wr;
    assign wdata     = r_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_wr    = r_rsp_wr;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_cmd_master
// Purpose  : Self-checking bench for reg_cmd_master with a register-bank model
//            and a transaction-level reference for responses and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_cmd_master;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr    = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          sel;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata     = '0;
    logic          ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_wr;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    reg_cmd_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .sel       (sel),
        .addr      (addr),
        .wr        (wr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a ^ 8'hA5, a};
    endfunction

    // Register bank: stalls stall_plan cycles per access, rdata one cycle late.
    logic [DW-1:0] bank_mem [0:255];
    bit            bank_vld [0:255];
    int            stall_plan = 0;
    int            stall_cnt  = 0;
    assign ready = (stall_cnt >= stall_plan);

    always @(posedge clk) begin
        if (!sel) stall_cnt <= 0;
        else if (!ready) stall_cnt <= stall_cnt + 1;
        if (sel && ready && wr) begin
            bank_mem[addr] <= wdata;
            bank_vld[addr] <= 1'b1;
        end
        if (sel && ready && !wr) rdata <= bank_vld[addr] ? bank_mem[addr] : init_val(addr);
    end

    // Reference register contents as seen by completed commands.
    logic [DW-1:0] ref_mem [0:255];
    bit            ref_vld [0:255];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_vld[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int stall, input int hold, input bit release_rsp);
        int            n, lat, sel_exp, sel_seen, t;
        bit            err, got;
        logic [DW-1:0] exp_rd;
        err     = (stall >= TO);
        lat     = err ? TO + 1 : (w ? 2 + stall : 3 + stall);
        sel_exp = err ? TO : (w ? 1 + stall : 2 + stall);
        exp_rd  = (w || err) ? '0 : ref_rd(a);
        if (w && !err) begin
            ref_mem[a] = d;
            ref_vld[a] = 1'b1;
        end
        @(negedge clk);
        stall_plan = stall;
        cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b0;
        #1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL accept_wait cmd_ready=%0b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        n = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (sel !== 1'b1 || addr !== a || wr !== w || (w && wdata !== d)) begin
            failures++;
            $display("FAIL issue_fields sel=%0b addr=%h wr=%0b wdata=%h required 1 %h %0b %h",
                     sel, addr, wr, wdata, a, w, d);
        end
        sel_seen = 0; got = 1'b0;
        for (int i = 0; i < TO + 40 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else begin
                if (sel) sel_seen++;
                @(negedge clk);
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rsp_wait rsp_valid=%0b required 1", rsp_valid);
            return;
        end
        checks++;
        if (cyc - n != lat) begin
            failures++;
            $display("FAIL latency got=%0d required=%0d (wr=%0b stall=%0d)", cyc - n, lat, w, stall);
        end
        checks++;
        if (sel_seen != sel_exp) begin
            failures++;
            $display("FAIL sel_cycles got=%0d required=%0d", sel_seen, sel_exp);
        end
        checks++;
        if (rsp_wr !== w || rsp_err !== err || rsp_rdata !== exp_rd) begin
            failures++;
            $display("FAIL rsp_fields wr=%0b err=%0b rdata=%h required %0b %0b %h",
                     rsp_wr, rsp_err, rsp_rdata, w, err, exp_rd);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_wr !== w || rsp_err !== err ||
                rsp_rdata !== exp_rd || cmd_ready !== 1'b0 || sel !== 1'b0) begin
                failures++;
                $display("FAIL rsp_hold valid=%0b wr=%0b err=%0b rdata=%h cmd_ready=%0b required 1 %0b %0b %h 0",
                         rsp_valid, rsp_wr, rsp_err, rsp_rdata, cmd_ready, w, err, exp_rd);
            end
        end
        if (release_rsp) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            #1;
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL release_ready cmd_ready=%0b required 1", cmd_ready);
            end
            @(negedge clk);
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rsp_clear rsp_valid=%0b required 0", rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (sel !== 1'b0 || wr !== 1'b0 || addr !== '0 || wdata !== '0 || rsp_valid !== 1'b0 ||
            rsp_wr !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values sel=%0b wr=%0b addr=%h wdata=%h rsp=%0b/%0b/%h/%0b required all 0",
                     sel, wr, addr, wdata, rsp_valid, rsp_wr, rsp_rdata, rsp_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready cmd_ready=%0b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        run_txn(1'b1, 8'h05, 16'hBEEF, 0, 0, 1'b1);
        run_txn(1'b0, 8'h05, 16'h1234, 0, 0, 1'b1);
        run_txn(1'b0, 8'h2A, 16'h0000, 2, 0, 1'b1);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 8'h05, 16'h0000, 40, 0, 1'b1);
        run_txn(1'b1, 8'h06, 16'hCAFE, TO, 1, 1'b1);
        run_txn(1'b1, 8'h07, 16'hF00D, TO - 1, 0, 1'b1);
        run_txn(1'b0, 8'h07, 16'h0000, 0, 0, 1'b1);
    endtask

    task automatic test_rsp_hold();
        int n;
        run_txn(1'b0, 8'h05, 16'h0000, 0, 10, 1'b0);
        @(negedge clk);
        stall_plan = 0;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h33; cmd_wdata = 16'h5A5A;
        ref_mem[8'h33] = 16'h5A5A; ref_vld[8'h33] = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL held_cmd_ready cmd_ready=%0b required 0", cmd_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL overlap_accept cmd_ready=%0b required 1", cmd_ready);
        end
        n = cyc;
        @(negedge clk);
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || sel !== 1'b1) begin
            failures++;
            $display("FAIL overlap_state rsp_valid=%0b sel=%0b required 0 1", rsp_valid, sel);
        end
        @(negedge clk);
        checks++;
        if (cyc - n != 2 || rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL overlap_rsp lat=%0d valid=%0b wr=%0b err=%0b required 2 1 1 0",
                     cyc - n, rsp_valid, rsp_wr, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        run_txn(1'b0, 8'h33, 16'h0000, 1, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        stall_plan = 0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h33; cmd_wdata = 16'h0F0F;
        #1;
        n = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sel !== 1'b1 || cyc - n != 2) begin
            failures++;
            $display("FAIL rd_data_phase sel=%0b cycle=%0d required 1 2", sel, cyc - n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sel !== 1'b0 || addr !== '0 || wr !== 1'b0 || wdata !== '0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset sel=%0b addr=%h wr=%0b wdata=%h rsp_valid=%0b required 0",
                     sel, addr, wr, wdata, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready cmd_ready=%0b required 1", cmd_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || sel !== 1'b0) begin
                failures++;
                $display("FAIL discarded_cmd rsp_valid=%0b sel=%0b required 0 0", rsp_valid, sel);
            end
        end
        run_txn(1'b0, 8'h33, 16'h0000, 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int            n1, n2, t;
        logic [DW-1:0] d;
        d = DW'($urandom);
        ref_mem[8'h44] = d; ref_vld[8'h44] = 1'b1;
        @(negedge clk);
        stall_plan = 0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h44; cmd_wdata = d;
        #1;
        t = 0;
        while (!cmd_ready && t < 20) begin @(negedge clk); #1; t++; end
        n1 = cyc;
        @(negedge clk);
        cmd_wr = 1'b0; cmd_wdata = DW'($urandom);
        #1;
        t = 0;
        while (!cmd_ready && t < 20) begin @(negedge clk); #1; t++; end
        n2 = cyc;
        checks++;
        if (n2 - n1 != 2 || rsp_valid !== 1'b1 || rsp_wr !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept gap=%0d rsp_valid=%0b rsp_wr=%0b required 2 1 1",
                     n2 - n1, rsp_valid, rsp_wr);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (cyc - n2 != 3 || rsp_wr !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== d) begin
            failures++;
            $display("FAIL b2b_read lat=%0d wr=%0b err=%0b rdata=%h required 3 0 0 %h",
                     cyc - n2, rsp_wr, rsp_err, rsp_rdata, d);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        bit            w;
        logic [AW-1:0] a;
        int            r, stall;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r <= 5)      stall = $urandom_range(0, 3);
            else if (r == 6) stall = TO - 1;
            else if (r == 7) stall = TO;
            else if (r == 8) stall = TO + 2;
            else             stall = $urandom_range(4, 10);
            run_txn(w, a, DW'($urandom), stall, $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
        test_reset();
        test_write_read();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
